// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the program/data RAM arbiter: default sizes, requester ids
// and small helpers used by the arbiter and its round-robin picker.
package mem_arbiter_pkg;

  localparam int NUM_REQ_DEF  = 3;
  localparam int ADDR_W_DEF   = 8;
  localparam int DATA_W_DEF   = 32;
  localparam int LOCK_MAX_DEF = 16;

  // Requester slots; NUM_REQ never exceeds 4, so a 2-bit index covers every slot.
  localparam int IDX_W = 2;

  typedef enum logic [IDX_W-1:0] {
    ID_LOADER = 2'd0,
    ID_FETCH  = 2'd1,
    ID_DATA   = 2'd2,
    ID_SPARE  = 2'd3
  } req_id_e;

  localparam int REQ_LOADER = 0;
  localparam int REQ_FETCH  = 1;
  localparam int REQ_DATA   = 2;

  function automatic logic [3:0] idx_onehot(input logic [IDX_W-1:0] idx);
    return 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/mem_arbiter_rr_pick.sv
// Round-robin picker: one-hot selection of the first masked request found
// searching upward from last+1 with wrap-around.
module rr_pick
  import mem_arbiter_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last,
  input  logic [NUM_REQ-1:0] mask,
  output logic [NUM_REQ-1:0] pick
);

  logic [NUM_REQ-1:0] cand;
  logic               found;
  int                 pos;

  always_comb begin
    cand  = req & mask;
    pick  = '0;
    found = 1'b0;
    pos   = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      pos = int'(last) + k;
      if (pos >= NUM_REQ) begin
        pos = pos - NUM_REQ;
      end
      for (int j = 0; j < NUM_REQ; j++) begin
        if (!found && cand[j] && (pos == j)) begin
          pick[j] = 1'b1;
          found   = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter for loader / CPU fetch / CPU data with round-robin grant.
// Optional ownership locking is compiled in with MEM_ARB_LOCK_EN.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int NUM_REQ  = NUM_REQ_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
`ifdef MEM_ARB_LOCK_EN
  parameter int LOCK_MAX = LOCK_MAX_DEF,
`endif
  parameter int DATA_W   = DATA_W_DEF
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       pause,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ-1:0]         we,
  input  logic [NUM_REQ*ADDR_W-1:0]  addr,
  input  logic [NUM_REQ*DATA_W-1:0]  wdata,
`ifdef MEM_ARB_LOCK_EN
  input  logic [NUM_REQ-1:0]         lock,
`endif
  output logic [NUM_REQ-1:0]         gnt,
  output logic [NUM_REQ-1:0]         rvalid,
  output logic [DATA_W-1:0]          rdata,
  output logic                       mem_en,
  output logic                       mem_we,
  output logic [ADDR_W-1:0]          mem_addr,
  output logic [DATA_W-1:0]          mem_wdata,
  input  logic [DATA_W-1:0]          mem_rdata
);

  localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NUM_REQ - 1);

  logic [IDX_W-1:0]   last_q, last_d;
  logic [NUM_REQ-1:0] rvalid_q, rvalid_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [DATA_W-1:0]  wdata_q, wdata_d;
  logic [NUM_REQ-1:0] mask;
  logic [NUM_REQ-1:0] pick;
  logic [IDX_W-1:0]   gnt_idx;
  logic               gnt_lock;

`ifdef MEM_ARB_LOCK_EN
  // own | meaning
  // 0   | free: round-robin over all requesters
  // 1   | owned: only owner_q is eligible, cnt_q grants taken so far
  localparam int CNT_W = $clog2(LOCK_MAX + 1);

  logic               own_q, own_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W:0]     cnt_inc;
  logic [3:0]         owner_oh4;
  logic [NUM_REQ-1:0] owner_oh;

  always_comb begin
    owner_oh4 = idx_onehot(owner_q);
    owner_oh  = owner_oh4[NUM_REQ-1:0];
    mask      = own_q ? owner_oh : '1;
  end
`else
  assign mask = '1;
`endif

  rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_pick (
    .req  (req),
    .last (last_q),
    .mask (mask),
    .pick (pick)
  );

  // Without a grant the RAM bus keeps its last driven address/data, so no X leaks out.
  always_comb begin
    gnt       = (reset || pause) ? '0 : pick;
    mem_en    = |gnt;
    mem_we    = 1'b0;
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
    gnt_idx   = last_q;
    gnt_lock  = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        mem_we    = we[i];
        mem_addr  = addr[i*ADDR_W +: ADDR_W];
        mem_wdata = wdata[i*DATA_W +: DATA_W];
        gnt_idx   = IDX_W'(i);
`ifdef MEM_ARB_LOCK_EN
        gnt_lock  = lock[i];
`endif
      end
    end
    last_d   = gnt_idx;
    addr_d   = mem_addr;
    wdata_d  = mem_wdata;
    rvalid_d = gnt & ~we;
  end

`ifdef MEM_ARB_LOCK_EN
  always_comb begin
    own_d   = own_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    cnt_inc = (own_q ? {1'b0, cnt_q} : '0) + (CNT_W+1)'(1);
    if (mem_en) begin
      if (gnt_lock && (cnt_inc < (CNT_W+1)'(LOCK_MAX))) begin
        own_d   = 1'b1;
        owner_d = gnt_idx;
        cnt_d   = cnt_inc[CNT_W-1:0];
      end else begin
        own_d = 1'b0;
        cnt_d = '0;
      end
    end else if (own_q && !(|(req & owner_oh))) begin
      own_d = 1'b0;
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      own_q   <= 1'b0;
      owner_q <= '0;
      cnt_q   <= '0;
    end else begin
      own_q   <= own_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
    end
  end
`else
  logic unused_lock;
  assign unused_lock = gnt_lock;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      last_q   <= LAST_RST;
      rvalid_q <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else begin
      last_q   <= last_d;
      rvalid_q <= rvalid_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
    end
  end

  // A read in flight when reset arrives must not be reported.
  assign rvalid = reset ? '0 : rvalid_q;
  assign rdata  = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: rule-level reference model checked every cycle
// plus directed scenarios with hand-computed expectations.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int N  = 3;
  localparam int AW = 8;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset, pause;
  logic [N-1:0]  req, we, gnt, rvalid;
  logic [N*AW-1:0] addr;
  logic [N*DW-1:0] wdata;
  logic [DW-1:0] rdata, mem_wdata, mem_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
`ifdef MEM_ARB_LOCK_EN
  logic [N-1:0]  lock;
`endif

  int errors = 0;
  int checks = 0;
  bit run_chk = 1'b0;

  logic [DW-1:0] ram  [256];
  logic [DW-1:0] mmem [256];

  // reference model state
  int            m_last  = N - 1;
  bit            m_pend  = 1'b0;
  int            m_pidx  = 0;
  logic [DW-1:0] m_pdata = '0;
  logic [AW-1:0] m_haddr = '0;
  logic [DW-1:0] m_hwd   = '0;
  int            m_owner = -1;
  int            m_cnt   = 0;

  mem_arbiter dut (
    .clk       (clk),
    .reset     (reset),
    .pause     (pause),
    .req       (req),
    .we        (we),
    .addr      (addr),
    .wdata     (wdata),
`ifdef MEM_ARB_LOCK_EN
    .lock      (lock),
`endif
    .gnt       (gnt),
    .rvalid    (rvalid),
    .rdata     (rdata),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata     <= ram[mem_addr];
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic int model_pick(int last, logic [N-1:0] r, logic p, int owner);
    if (p) return -1;
    if (owner >= 0) return r[owner] ? owner : -1;
    for (int k = 1; k <= N; k++) begin
      if (r[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  int            g;
  int            n_own;
  logic [N-1:0]  e_gnt, e_rv;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_wd;

  always @(negedge clk) begin
    if (run_chk) begin
      if (reset) begin
        chk("gnt_in_reset", gnt, 0);
        chk("mem_en_in_reset", mem_en, 0);
        chk("rvalid_in_reset", rvalid, 0);
        m_last = N - 1; m_pend = 1'b0; m_haddr = '0; m_hwd = '0;
        m_owner = -1; m_cnt = 0;
      end else begin
        g = model_pick(m_last, req, pause, m_owner);
        e_gnt = '0;
        if (g >= 0) e_gnt[g] = 1'b1;
        e_rv = '0;
        if (m_pend) e_rv[m_pidx] = 1'b1;
        e_addr = (g >= 0) ? addr[g*AW +: AW] : m_haddr;
        e_wd   = (g >= 0) ? wdata[g*DW +: DW] : m_hwd;
        chk("gnt", gnt, e_gnt);
        chk("mem_en", mem_en, (g >= 0));
        chk("mem_we", mem_we, (g >= 0) ? we[g] : 1'b0);
        chk("mem_addr", mem_addr, e_addr);
        chk("mem_wdata", mem_wdata, e_wd);
        chk("rvalid", rvalid, e_rv);
        if (m_pend) chk("rdata", rdata, m_pdata);
        m_pend = (g >= 0) && !we[g];
        if (g >= 0) begin
          m_pidx  = g;
          m_pdata = mmem[e_addr];
          m_last  = g;
          m_haddr = e_addr;
          m_hwd   = e_wd;
          if (we[g]) mmem[e_addr] = e_wd;
        end
`ifdef MEM_ARB_LOCK_EN
        if (g >= 0) begin
          n_own = ((m_owner >= 0) ? m_cnt : 0) + 1;
          if (lock[g] && n_own < 16) begin m_owner = g; m_cnt = n_own; end
          else begin m_owner = -1; m_cnt = 0; end
        end else if (m_owner >= 0 && !req[m_owner]) begin
          m_owner = -1; m_cnt = 0;
        end
`endif
      end
    end
  end

  logic [N-1:0] seq [4];
  logic [3*N-1:0] vec [10];
  int run_len;
  bit seen;

  initial begin
    seq[0] = 3'b001; seq[1] = 3'b010; seq[2] = 3'b100; seq[3] = 3'b001;
    vec[0] = {1'b0, 3'b011, 3'b001}; vec[1] = {1'b0, 3'b011, 3'b000};
    vec[2] = {1'b0, 3'b101, 3'b100}; vec[3] = {1'b1, 3'b111, 3'b000};
    vec[4] = {1'b0, 3'b111, 3'b010}; vec[5] = {1'b0, 3'b110, 3'b110};
    vec[6] = {1'b0, 3'b000, 3'b000}; vec[7] = {1'b0, 3'b111, 3'b111};
    vec[8] = {1'b0, 3'b111, 3'b000}; vec[9] = {1'b0, 3'b000, 3'b000};
    for (int a = 0; a < 256; a++) begin
      ram[a]  = 32'h1000_0000 + a * 32'h0101;
      mmem[a] = 32'h1000_0000 + a * 32'h0101;
    end
    reset = 1'b1; pause = 1'b0; req = '0; we = '0; addr = '0; wdata = '0;
`ifdef MEM_ARB_LOCK_EN
    lock = '0;
`endif
    run_chk = 1'b1;
    repeat (2) cyc();
    reset = 1'b0;

    // 1: all three reading every cycle
    addr = {8'h30, 8'h20, 8'h10};
    req  = 3'b111;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("t1_gnt_seq", gnt, seq[k]);
      if (k > 0) chk("t1_rvalid_seq", rvalid, seq[k-1]);
      cyc();
    end
    req = '0;
    @(negedge clk);
    chk("t1_rvalid_last", rvalid, 3'b001);
    chk("t1_rdata_last", rdata, 32'h1000_1010);
    cyc();

    // 2: loader write then fetch read of the same word
    req = 3'b001; we = 3'b001; addr[7:0] = 8'h05; wdata[31:0] = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("t2_gnt_wr", gnt, 3'b001);
    chk("t2_mem_we_wr", mem_we, 1'b1);
    cyc();
    req = 3'b010; we = 3'b000; addr[15:8] = 8'h05;
    @(negedge clk);
    chk("t2_gnt_rd", gnt, 3'b010);
    chk("t2_mem_we_rd", mem_we, 1'b0);
    cyc();
    req = '0;
    @(negedge clk);
    chk("t2_rvalid", rvalid, 3'b010);
    chk("t2_rdata", rdata, 32'hDEAD_BEEF);
    cyc();

    // 3: data port alone for four cycles
    req = 3'b100; addr[23:16] = 8'h33;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("t3_gnt", gnt, 3'b100);
      cyc();
    end
    req = '0;
    @(negedge clk);
    chk("t3_rvalid_tail", rvalid, 3'b100);
    chk("t3_mem_en_off", mem_en, 1'b0);
    cyc();
    @(negedge clk);
    chk("t3_mem_en_idle", mem_en, 1'b0);
    chk("t3_rvalid_idle", rvalid, 3'b000);
    cyc();

    // 4: pause blocks grants but not an rvalid already owed
    pause = 1'b1; req = 3'b110;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("t4_gnt_paused", gnt, 3'b000);
      chk("t4_mem_en_paused", mem_en, 1'b0);
      cyc();
    end
    pause = 1'b0;
    @(negedge clk);
    chk("t4_gnt_release", gnt, 3'b010);
    cyc();
    pause = 1'b1; req = 3'b100;
    @(negedge clk);
    chk("t4_rvalid_under_pause", rvalid, 3'b010);
    chk("t4_gnt_paused2", gnt, 3'b000);
    cyc();

    // 5: reset right after a read grant
    pause = 1'b0;
    @(negedge clk);
    chk("t5_gnt_read", gnt, 3'b100);
    cyc();
    reset = 1'b1; req = '0;
    @(negedge clk);
    chk("t5_rvalid_cancel", rvalid, 3'b000);
    cyc();
    reset = 1'b0; req = 3'b111; we = '0;
    @(negedge clk);
    chk("t5_first_gnt", gnt, 3'b001);
    cyc();
    req = '0;
    cyc();

    // mixed vectors checked by the reference model
    addr  = {8'h05, 8'h44, 8'h33};
    wdata = {32'h2222_0002, 32'h1111_0001, 32'h0000_0A00};
    for (int v = 0; v < 10; v++) begin
      {pause, req, we} = vec[v];
      cyc();
    end
    pause = 1'b0; req = '0; we = '0;
    cyc();

`ifdef MEM_ARB_LOCK_EN
    // 6: data port locks ownership until forced release
    reset = 1'b1; cyc(); reset = 1'b0;
    lock = 3'b100; req = 3'b111; we = '0;
    run_len = 0; seen = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (gnt == 3'b100) begin
        run_len++;
        seen = 1'b1;
      end else if (seen) begin
        break;
      end
      cyc();
    end
    chk("t6_lock_run", run_len, 16);
    chk("t6_after_release", gnt, 3'b001);
    cyc();
    lock = '0; req = '0;
    cyc();
`endif

    repeat (2) cyc();
    run_chk = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
